// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
// Counter width helper sizes the ACCESS watchdog.
package ahb_apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // The counter only has to reach limit-1 before the abort fires.
  function automatic int ctr_width(input int limit);
    if (limit <= 2) return 1;
    return $clog2(limit);
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_gen_ctr.sv
// Clearable, saturating ACCESS-cycle counter.
// Expired flags the last permitted ACCESS cycle.
module apb_timeout_ctr #(
  parameter int LIMIT = 256,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST =
    W'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/ahb_apb_bridge_gen.sv
// AHB-Lite slave to APB3 master bridge with slot decode,
// PREADY watchdog and two-cycle ERROR responses.
module ahb_apb_bridge_gen
  import ahb_apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SLOTS      = 16,
  parameter int SLOT_LSB       = 8,
  parameter int SLOT_BITS      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [NUM_SLOTS-1:0]  PSEL,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  TIMEOUT_EVT
);

  localparam int CW = ctr_width(TIMEOUT_CYCLES);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   write_q;
  logic [SLOT_BITS-1:0]   slot_q;
  logic [SLOT_BITS-1:0]   slot_in;
  logic                   ready_st;
  logic                   accept;
  logic                   in_range;
  logic                   expired;
  logic                   unused_htrans;

  assign unused_htrans = HTRANS[0];

  assign slot_in  = HADDR[SLOT_LSB +: SLOT_BITS];
  assign in_range = 32'(slot_in) < NUM_SLOTS;

  assign ready_st = (state == ST_IDLE) ||
                    (state == ST_DONE) ||
                    (state == ST_ERR2);

  assign accept = ready_st & HSEL &
                  HREADYIN & HTRANS[1];

  apb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (CW)
  ) u_ctr (
    .clk     (HCLK),
    .rst     (HRESET),
    .clr     (state == ST_WDATA),
    .en      (state == ST_ACCESS),
    .expired (expired)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      HREADYOUT   <= 1'b1;
      HRESP       <= HRESP_OKAY;
      HRDATA      <= '0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      TIMEOUT_EVT <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      slot_q      <= '0;
    end else begin
      TIMEOUT_EVT <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          if (accept) begin
            addr_q    <= HADDR;
            write_q   <= HWRITE;
            slot_q    <= slot_in;
            HREADYOUT <= 1'b0;
            if (in_range) begin
              state <= ST_WDATA;
              HRESP <= HRESP_OKAY;
            end else begin
              state <= ST_ERR1;
              HRESP <= HRESP_ERROR;
            end
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
        ST_WDATA: begin
          // Data phase: HWDATA is only valid now.
          PWDATA <= HWDATA;
          PSEL   <= NUM_SLOTS'(1) << slot_q;
          PADDR  <= addr_q;
          PWRITE <= write_q;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              state <= ST_ERR1;
              HRESP <= HRESP_ERROR;
            end else begin
              state     <= ST_DONE;
              HREADYOUT <= 1'b1;
              if (!write_q) HRDATA <= PRDATA;
            end
          end else if (expired) begin
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            state       <= ST_ERR1;
            HRESP       <= HRESP_ERROR;
            TIMEOUT_EVT <= 1'b1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_gen.sv
// Randomised bench with a transaction-level timeline model
// of the bridge plus directed literal checks.
module tb_ahb_apb_bridge_gen;

  localparam int NS = 12;
  localparam int TO = 8;

  logic          clk;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [31:0]   HWDATA;
  logic          HREADYIN;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [NS-1:0] PSEL;
  logic [31:0]   PADDR;
  logic          PWRITE;
  logic          PENABLE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic          TIMEOUT_EVT;

  ahb_apb_bridge_gen #(
    .ADDR_WIDTH     (32),
    .NUM_SLOTS      (NS),
    .SLOT_LSB       (8),
    .SLOT_BITS      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .HCLK        (clk),
    .HRESET      (HRESET),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HTRANS      (HTRANS),
    .HWDATA      (HWDATA),
    .HREADYIN    (HREADYIN),
    .HREADYOUT   (HREADYOUT),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .PSEL        (PSEL),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PENABLE     (PENABLE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .TIMEOUT_EVT (TIMEOUT_EVT)
  );

  typedef struct packed {
    logic          hready;
    logic          hresp;
    logic [31:0]   hrdata;
    logic [NS-1:0] psel;
    logic          penable;
    logic [31:0]   paddr;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic          tevt;
  } want_t;

  want_t       want;
  logic [31:0] m_paddr, m_pwdata, m_hrdata;
  logic        m_pwrite;
  logic        prev_hready;
  int n_chk, n_err;
  int n_pen, n_tevt, n_hresp, n_psel;
  int cyc, a_cyc, s_cyc, r_cyc;
  logic [NS-1:0] s_psel;
  logic [31:0]   s_pwdata, s_paddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic want_t base(input logic hr,
                                 input logic rs);
    want_t w;
    w.hready  = hr;
    w.hresp   = rs;
    w.hrdata  = m_hrdata;
    w.psel    = '0;
    w.penable = 1'b0;
    w.paddr   = m_paddr;
    w.pwrite  = m_pwrite;
    w.pwdata  = m_pwdata;
    w.tevt    = 1'b0;
    return w;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, req, $time);
    end
  endtask

  task automatic close();
    @(negedge clk);
    chk("hreadyout", 32'(HREADYOUT), 32'(want.hready));
    chk("hresp", 32'(HRESP), 32'(want.hresp));
    chk("hrdata", HRDATA, want.hrdata);
    chk("psel", 32'(PSEL), 32'(want.psel));
    chk("penable", 32'(PENABLE), 32'(want.penable));
    chk("paddr", PADDR, want.paddr);
    chk("pwrite", 32'(PWRITE), 32'(want.pwrite));
    chk("pwdata", PWDATA, want.pwdata);
    chk("timeout_evt", 32'(TIMEOUT_EVT), 32'(want.tevt));
    if (PENABLE) n_pen++;
    if (TIMEOUT_EVT) n_tevt++;
    if (HRESP) n_hresp++;
    if (PSEL != '0) n_psel++;
    if (PSEL != '0 && !PENABLE) begin
      s_psel = PSEL; s_pwdata = PWDATA;
      s_paddr = PADDR; s_cyc = cyc;
    end
    if (HREADYOUT && !HRESP && !prev_hready) r_cyc = cyc;
    prev_hready = HREADYOUT;
  endtask

  task automatic open();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic noacc();
    HSEL     = 1'($urandom);
    HREADYIN = 1'($urandom);
    HTRANS   = 2'($urandom);
    HADDR    = $urandom;
    HWRITE   = 1'($urandom);
    HWDATA   = $urandom;
    PREADY   = 1'($urandom);
    PSLVERR  = 1'($urandom);
    PRDATA   = $urandom;
    case ($urandom_range(0, 2))
      0: HSEL = 1'b0;
      1: HREADYIN = 1'b0;
      default: HTRANS[1] = 1'b0;
    endcase
  endtask

  task automatic step();
    close();
    open();
    noacc();
  endtask

  task automatic gap();
    open();
    noacc();
    want = base(1'b1, 1'b0);
  endtask

  task automatic xfer(input logic [31:0] a,
                      input logic wr,
                      input logic [31:0] wd,
                      input logic [31:0] rd,
                      input int wt,
                      input logic se,
                      input int rst_at);
    logic [NS-1:0] sel;
    int acc;
    bit to;
    sel = NS'(1) << a[11:8];
    HSEL = 1'b1;
    HREADYIN = 1'b1;
    HTRANS = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    HADDR = a;
    HWRITE = wr;
    a_cyc = cyc;
    step();
    HWDATA = wd;
    if (int'(a[11:8]) >= NS) begin
      want = base(1'b0, 1'b1);
      step();
      want = base(1'b1, 1'b1);
      return;
    end
    want = base(1'b0, 1'b0);
    step();
    m_paddr = a; m_pwrite = wr; m_pwdata = wd;
    want = base(1'b0, 1'b0);
    want.psel = sel;
    to = (wt >= TO);
    acc = to ? TO : wt + 1;
    for (int j = 0; j < acc; j++) begin
      step();
      want = base(1'b0, 1'b0);
      want.psel = sel;
      want.penable = 1'b1;
      PREADY = (j == wt);
      if (j == wt) PSLVERR = se;
      if (j == wt) PRDATA = rd;
      if (j == rst_at) begin
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        m_paddr = '0; m_pwdata = '0;
        m_hrdata = '0; m_pwrite = 1'b0;
        want = base(1'b1, 1'b0);
        return;
      end
    end
    step();
    if (!to && !se) begin
      if (!wr) m_hrdata = rd;
      want = base(1'b1, 1'b0);
    end else begin
      want = base(1'b0, 1'b1);
      want.tevt = to;
      step();
      want = base(1'b1, 1'b1);
    end
  endtask

  int p_pen, p_tevt, p_hresp, p_psel;

  task automatic snap();
    p_pen = n_pen; p_tevt = n_tevt;
    p_hresp = n_hresp; p_psel = n_psel;
  endtask

  initial begin
    logic [31:0] a;
    int rst_at;
    n_chk = 0; n_err = 0; cyc = 0;
    n_pen = 0; n_tevt = 0; n_hresp = 0; n_psel = 0;
    s_cyc = 0; r_cyc = 0; a_cyc = 0;
    s_psel = '0; s_pwdata = '0; s_paddr = '0;
    prev_hready = 1'b1;
    m_paddr = '0; m_pwdata = '0;
    m_hrdata = '0; m_pwrite = 1'b0;
    HRESET = 1'b1;
    noacc();
    open();
    want = base(1'b1, 1'b0);
    step();
    HRESET = 1'b0;
    repeat (3) step();

    snap();
    xfer(32'h0000_0304, 1'b1, 32'hDEAD_BEEF,
         32'h0, 0, 1'b0, -1);
    close();
    chk("lit_setup_psel", 32'(s_psel), 32'h0000_0008);
    chk("lit_setup_pwdata", s_pwdata, 32'hDEAD_BEEF);
    chk("lit_setup_paddr", s_paddr, 32'h0000_0304);
    chk("lit_setup_latency", 32'(s_cyc - a_cyc), 32'd2);
    chk("lit_done_latency", 32'(r_cyc - a_cyc), 32'd4);
    chk("lit_w_access_len", 32'(n_pen - p_pen), 32'd1);
    gap();

    snap();
    xfer(32'h0000_0A10, 1'b0, 32'h5555_AAAA,
         32'h1234_5678, 5, 1'b0, -1);
    close();
    chk("lit_rd_hrdata", HRDATA, 32'h1234_5678);
    chk("lit_rd_access_len", 32'(n_pen - p_pen), 32'd6);
    gap();

    snap();
    xfer(32'h0000_0C20, 1'b1, 32'h1, 32'h2, 0, 1'b0, -1);
    close();
    chk("lit_oor_psel_cyc", 32'(n_psel - p_psel), 32'd0);
    chk("lit_oor_hresp_cyc", 32'(n_hresp - p_hresp), 32'd2);
    gap();

    snap();
    xfer(32'h0000_0040, 1'b1, 32'h3, 32'h4, 0, 1'b1, -1);
    close();
    chk("lit_slverr_hresp_cyc", 32'(n_hresp - p_hresp), 32'd2);
    chk("lit_slverr_hrdata", HRDATA, 32'h1234_5678);
    gap();

    snap();
    xfer(32'h0000_0580, 1'b0, 32'h5, 32'h6, 20, 1'b0, -1);
    close();
    chk("lit_to_access_len", 32'(n_pen - p_pen), 32'd8);
    chk("lit_to_pulses", 32'(n_tevt - p_tevt), 32'd1);
    chk("lit_to_hresp_cyc", 32'(n_hresp - p_hresp), 32'd2);
    gap();

    snap();
    xfer(32'h0000_0580, 1'b0, 32'h7, 32'hCAFE_F00D,
         TO - 1, 1'b0, -1);
    close();
    chk("lit_edge_access_len", 32'(n_pen - p_pen), 32'd8);
    chk("lit_edge_pulses", 32'(n_tevt - p_tevt), 32'd0);
    chk("lit_edge_hresp_cyc", 32'(n_hresp - p_hresp), 32'd0);
    chk("lit_edge_hrdata", HRDATA, 32'hCAFE_F00D);
    gap();

    xfer(32'h0000_0100, 1'b1, 32'h8, 32'h9, 1, 1'b0, -1);
    xfer(32'h0000_0200, 1'b0, 32'hA, 32'h0BAD_F00D,
         0, 1'b0, -1);
    close();
    chk("lit_b2b_hrdata", HRDATA, 32'h0BAD_F00D);
    gap();

    xfer(32'h0000_0700, 1'b1, 32'hB, 32'hC, 10, 1'b0, 2);
    close();
    chk("lit_rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("lit_rst_psel", 32'(PSEL), 32'd0);
    chk("lit_rst_penable", 32'(PENABLE), 32'd0);
    gap();

    repeat (200) begin
      a = $urandom;
      a[11:8] = 4'($urandom_range(0, 15));
      rst_at = -1;
      if ($urandom_range(0, 24) == 0)
        rst_at = $urandom_range(0, 3);
      xfer(a, 1'($urandom), $urandom, $urandom,
           $urandom_range(0, 10),
           ($urandom_range(0, 4) == 0), rst_at);
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 3)) begin
          close();
          gap();
        end
      end
    end
    close();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge_gen.md
Name: ahb_apb_bridge_gen

Overview:
Parametrised AHB-Lite slave to APB3 master bridge. It is the next generation of the fixed 16-slot bridge used behind the BFM and CoreUART subsystem test harnesses. New relative to that bridge:
- generic slot count and address width;
- out-of-range slot decode produces an AHB ERROR with no APB access;
- PREADY timeout watchdog;
- PSLVERR mapped to a two-cycle AHB ERROR response.

Parameters:
ADDR_WIDTH, 32, width of HADDR and PADDR.
NUM_SLOTS, 16, number of APB slaves and width of PSEL; range 1..32.
SLOT_LSB, 8, lowest HADDR bit of the slot index field.
SLOT_BITS, 4, width of the slot index field; 2**SLOT_BITS >= NUM_SLOTS.
TIMEOUT_CYCLES, 256, maximum ACCESS cycles allowed before abort; 0 disables the watchdog.

Ports:
HCLK  in  1  single clock for the AHB and APB sides (PCLK = HCLK).
HRESET  in  1  synchronous reset, active-high.
HSEL  in  1  AHB slave select.
HADDR  in  ADDR_WIDTH  AHB address.
HWRITE  in  1  AHB write, 1 = write.
HTRANS  in  2  AHB transfer type; only bit 1 is used (NONSEQ/SEQ).
HWDATA  in  32  AHB write data, valid in the data phase.
HREADYIN  in  1  AHB bus ready.
HREADYOUT  out  1  slave ready.
HRDATA  out  32  read data.
HRESP  out  1  1 = ERROR.
PSEL  out  NUM_SLOTS  one-hot APB select.
PADDR  out  ADDR_WIDTH  APB address.
PWRITE  out  1  APB write.
PENABLE  out  1  APB enable.
PWDATA  out  32  APB write data.
PRDATA  in  32  read data from the selected slave, muxed externally.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB slave error.
TIMEOUT_EVT  out  1  one-cycle pulse when an access is aborted by the watchdog.

Behaviour:
- Reset (sync, HRESET=1 at a HCLK edge; abandons any in-flight access immediately):
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, TIMEOUT_EVT=0.
  - Watchdog counter=0, state=IDLE.
- Accept condition: HSEL & HREADYIN & HTRANS[1], sampled only in IDLE, DONE and ERR2 (the states where HREADYOUT=1).
- On accept:
  - Register HADDR, HWRITE and the slot index HADDR[SLOT_LSB+SLOT_BITS-1:SLOT_LSB].
  - Index >= NUM_SLOTS -> ERR1; otherwise -> WDATA.
- State machine:
  - IDLE: HREADYOUT=1, HRESP=0. Exit on accept.
  - WDATA: HREADYOUT=0. Capture HWDATA into PWDATA for both reads and writes. -> SETUP.
  - SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE from registers, HREADYOUT=0. -> ACCESS.
  - ACCESS: PSEL held, PENABLE=1, HREADYOUT=0. Watchdog counts up by 1 per cycle.
    - PREADY & !PSLVERR -> DONE, with HRDATA<=PRDATA on reads.
    - PREADY & PSLVERR -> ERR1 (HRDATA unchanged).
    - !PREADY and count == TIMEOUT_CYCLES-1 -> ERR1, with TIMEOUT_EVT=1 for that transition cycle.
  - DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Accept -> WDATA/ERR1; else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0, PENABLE=0. -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept -> WDATA/ERR1; else IDLE.
- APB outputs are registered and take effect on entry to the state. PADDR, PWRITE and PWDATA hold their last value in IDLE.
- Latency, no wait states: accept edge N; SETUP visible cycle N+2; ACCESS N+3; HREADYOUT=1 in DONE at N+4.
- Watchdog:
  - Clears on SETUP entry.
  - Saturates; never wraps.
  - TIMEOUT_CYCLES=0 means no abort.
  - A PREADY arriving in the same cycle as the limit wins: normal completion, no TIMEOUT_EVT.
- HSIZE, HBURST, HPROT and HMASTLOCK are not ports; bursts are handled as back-to-back single transfers.
- HRESP stays 1 for exactly ERR1 and ERR2; it is 0 in every other state.

Decomposition:
- Package ahb_apb_bridge_pkg holds:
  - state enum (IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2);
  - HTRANS codes (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP_OKAY/HRESP_ERROR;
  - the function computing the counter width from TIMEOUT_CYCLES.
- One sub-module: apb_timeout_ctr, a clear/enable/saturating counter with an "expired" compare output.

Test Plan:
- Write 0xDEADBEEF to HADDR 0x0000_0304 (slot 3) -> PSEL=16'h0008 and PWDATA=0xDEADBEEF in SETUP at N+2; PENABLE=1 at N+3; HREADYOUT=1, HRESP=0 at N+4.
- Read HADDR 0x0000_0A10 (slot 10), PREADY low for 5 ACCESS cycles, PRDATA=0x12345678 -> HRDATA=0x12345678 in DONE; ACCESS lasts 6 cycles.
- Access slot 12 with NUM_SLOTS=8 -> no PSEL activity; HRESP=1 for 2 cycles; HREADYOUT 0 then 1.
- PSLVERR=1 with PREADY=1 on a write to slot 0 -> ERR1/ERR2 sequence; HRDATA unchanged.
- TIMEOUT_CYCLES=4, PREADY stuck low -> exactly 4 ACCESS cycles; TIMEOUT_EVT pulses once; PSEL drops; 2-cycle ERROR. Repeat with PREADY rising in the 4th cycle -> OKAY, no pulse.
- Back-to-back NONSEQ accepted in DONE; HRESET asserted mid-ACCESS -> next cycle PSEL=0, PENABLE=0, HREADYOUT=1, state IDLE.
